// File: rtl/cvxif_copro_issue_queue.sv
// In-order issue queue for a custom-0 CV-X-IF coprocessor. Instructions wait here
// until the core commits or kills them. Committed heads go through a one-cycle ALU
// into a registered result port.
module cvxif_copro_issue_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ID_W   = 3,
  parameter int unsigned XLEN   = 64,
  parameter logic [6:0]  OPCODE = 7'b0001011
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [XLEN-1:0] issue_rs1_i,
  input  logic [XLEN-1:0] issue_rs2_i,
  input  logic [ID_W-1:0] issue_id_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [XLEN-1:0] result_data_o,
  output logic [4:0]      result_rd_o,
  output logic            result_we_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_XOR  = 2'd1,
    OP_SLL  = 2'd2,
    OP_SLTU = 2'd3
  } alu_op_e;

  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_commit;
  logic [DEPTH-1:0] ent_kill;
  logic [ID_W-1:0]  ent_id  [DEPTH];
  logic [4:0]       ent_rd  [DEPTH];
  alu_op_e          ent_op  [DEPTH];
  logic [XLEN-1:0]  ent_rs1 [DEPTH];
  logic [XLEN-1:0]  ent_rs2 [DEPTH];

  logic       dec_ok;
  alu_op_e    dec_op;
  logic [4:0] dec_rd;
  logic       unused_instr;

  // Accepted funct3 values are 0..3, so bit 14 must be clear.
  assign dec_ok       = (issue_instr_i[6:0] == OPCODE) && !issue_instr_i[14];
  assign dec_op       = alu_op_e'(issue_instr_i[13:12]);
  assign dec_rd       = issue_instr_i[11:7];
  assign unused_instr = ^issue_instr_i[31:15];

  assign issue_ready_o     = (count < FULL_CNT);
  assign issue_accept_o    = issue_valid_i && issue_ready_o && dec_ok;
  assign issue_writeback_o = issue_accept_o;

  logic             push_req;
  logic             queue_empty;
  logic             new_match;
  logic             bypass;
  logic [DEPTH-1:0] match;
  logic [DEPTH-1:0] eff_commit;
  logic [DEPTH-1:0] eff_kill;

  assign push_req    = issue_accept_o;
  assign queue_empty = (count == '0);
  assign new_match   = push_req && commit_valid_i && (commit_id_i == issue_id_i);
  // An empty queue lets a same-cycle issue+commit go straight to the head logic.
  assign bypass      = queue_empty && new_match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi]      = ent_valid[gi] && commit_valid_i && (ent_id[gi] == commit_id_i);
      assign eff_commit[gi] = ent_commit[gi] || (match[gi] && !commit_kill_i);
      assign eff_kill[gi]   = ent_kill[gi] || (match[gi] && commit_kill_i);
    end
  endgenerate

  logic [ID_W-1:0] sel_id;
  logic [4:0]      sel_rd;
  alu_op_e         sel_op;
  logic [XLEN-1:0] sel_rs1;
  logic [XLEN-1:0] sel_rs2;
  logic            sel_commit;
  logic            sel_kill;

  always_comb begin
    sel_id     = ent_id[head];
    sel_rd     = ent_rd[head];
    sel_op     = ent_op[head];
    sel_rs1    = ent_rs1[head];
    sel_rs2    = ent_rs2[head];
    sel_commit = !queue_empty && eff_commit[head];
    sel_kill   = !queue_empty && eff_kill[head];
    if (bypass) begin
      sel_id     = issue_id_i;
      sel_rd     = dec_rd;
      sel_op     = dec_op;
      sel_rs1    = issue_rs1_i;
      sel_rs2    = issue_rs2_i;
      sel_commit = !commit_kill_i;
      sel_kill   = commit_kill_i;
    end
  end

  logic [XLEN-1:0] alu_res;

  always_comb begin
    alu_res = '0;
    case (sel_op)
      OP_ADD:  alu_res = sel_rs1 + sel_rs2;
      OP_XOR:  alu_res = sel_rs1 ^ sel_rs2;
      OP_SLL:  alu_res = sel_rs1 << sel_rs2[SH_W-1:0];
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (sel_rs1 < sel_rs2)};
      default: alu_res = '0;
    endcase
  end

  logic out_free;
  logic do_load;
  logic consumed;
  logic do_pop;
  logic do_push;

  assign out_free = !result_valid_o || result_ready_i;
  assign do_load  = sel_commit && !sel_kill && out_free;
  assign consumed = do_load || sel_kill;
  assign do_pop   = consumed && !bypass;
  assign do_push  = push_req && !(bypass && consumed);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else if (clr_i) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      head  <= head + PTR_W'(do_pop);
      tail  <= tail + PTR_W'(do_push);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Status flags; a push never lands on an occupied slot, so it may overwrite freely.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent_valid  <= '0;
      ent_commit <= '0;
      ent_kill   <= '0;
    end else if (clr_i) begin
      ent_valid  <= '0;
      ent_commit <= '0;
      ent_kill   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && (tail == PTR_W'(i))) begin
          ent_valid[i]  <= 1'b1;
          ent_commit[i] <= new_match && !commit_kill_i;
          ent_kill[i]   <= new_match && commit_kill_i;
        end else begin
          if (do_pop && (head == PTR_W'(i))) begin
            ent_valid[i] <= 1'b0;
          end
          if (match[i]) begin
            if (commit_kill_i) begin
              ent_kill[i] <= 1'b1;
            end else begin
              ent_commit[i] <= 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) begin
      ent_id[tail]  <= issue_id_i;
      ent_rd[tail]  <= dec_rd;
      ent_op[tail]  <= dec_op;
      ent_rs1[tail] <= issue_rs1_i;
      ent_rs2[tail] <= issue_rs2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
    end else if (clr_i) begin
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_data_o  <= '0;
      result_rd_o    <= '0;
      result_we_o    <= 1'b0;
    end else if (do_load) begin
      result_valid_o <= 1'b1;
      result_id_o    <= sel_id;
      result_data_o  <= alu_res;
      result_rd_o    <= sel_rd;
      result_we_o    <= 1'b1;
    end else if (result_ready_i) begin
      result_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cvxif_copro_issue_queue.sv
// Bench for cvxif_copro_issue_queue: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based model.
module tb_cvxif_copro_issue_queue;

  localparam int DEPTH = 4;
  localparam int ID_W  = 3;
  localparam int XLEN  = 64;
  localparam logic [6:0] OPC = 7'b0001011;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic iv = 1'b0;
  logic [31:0] instr = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic [ID_W-1:0] iid = '0;
  logic cv = 1'b0;
  logic [ID_W-1:0] cid = '0;
  logic ckill = 1'b0;
  logic rr = 1'b1;

  logic ready, accept, wb, rv, rwe;
  logic [ID_W-1:0] rid;
  logic [XLEN-1:0] rdata;
  logic [4:0] rrd;

  always #5 clk = ~clk;

  cvxif_copro_issue_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .XLEN(XLEN), .OPCODE(OPC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .issue_valid_i(iv), .issue_ready_o(ready), .issue_instr_i(instr),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2), .issue_id_i(iid),
    .issue_accept_o(accept), .issue_writeback_o(wb),
    .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ckill),
    .result_valid_o(rv), .result_ready_i(rr), .result_id_o(rid),
    .result_data_o(rdata), .result_rd_o(rrd), .result_we_o(rwe)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [ID_W-1:0] id;
    logic [4:0]      rd;
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    bit              com;
    bit              kil;
  } ent_t;

  ent_t mq[$];
  bit m_rv = 1'b0;
  logic [ID_W-1:0] m_id;
  logic [XLEN-1:0] m_data;
  logic [4:0] m_rd;
  bit m_free, m_can;
  ent_t m_e;
  logic [ID_W-1:0] obs_ids[$];

  function automatic bit dec_ok(input logic [31:0] w);
    return (w[6:0] == OPC) && (w[14:12] <= 3'd3);
  endfunction

  function automatic logic [XLEN-1:0] alu(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (f3)
      3'd0:    return a + b;
      3'd1:    return a ^ b;
      3'd2:    return a << b[5:0];
      default: return (a < b) ? 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic bit in_q(input logic [ID_W-1:0] id);
    foreach (mq[k]) if (mq[k].id == id) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n || clr) begin
      mq.delete();
      m_rv = 1'b0;
    end else begin
      m_free = !m_rv || rr;
      m_can  = mq.size() < DEPTH;
      if (m_rv && rr) m_rv = 1'b0;
      if (iv && m_can && dec_ok(instr)) begin
        m_e.id = iid; m_e.rd = instr[11:7]; m_e.f3 = instr[14:12];
        m_e.a = rs1; m_e.b = rs2; m_e.com = 1'b0; m_e.kil = 1'b0;
        mq.push_back(m_e);
      end
      if (cv) begin
        foreach (mq[k]) begin
          if (mq[k].id == cid) begin
            if (ckill) mq[k].kil = 1'b1;
            else mq[k].com = 1'b1;
          end
        end
      end
      if (mq.size() > 0) begin
        if (mq[0].kil) begin
          void'(mq.pop_front());
        end else if (mq[0].com && m_free) begin
          m_rv = 1'b1;
          m_id = mq[0].id;
          m_rd = mq[0].rd;
          m_data = alu(mq[0].f3, mq[0].a, mq[0].b);
          void'(mq.pop_front());
        end
      end
    end
  end

  // Per-cycle comparison, sampled 1 time unit after the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      #1;
      chk("issue_ready", 64'(ready), 64'(mq.size() < DEPTH));
      if (mq.size() < DEPTH) begin
        chk("issue_accept", 64'(accept), 64'(iv && dec_ok(instr)));
        chk("issue_writeback", 64'(wb), 64'(iv && dec_ok(instr)));
      end
      chk("result_valid", 64'(rv), 64'(m_rv));
      if (m_rv) begin
        chk("result_id", 64'(rid), 64'(m_id));
        chk("result_data", rdata, m_data);
        chk("result_rd", 64'(rrd), 64'(m_rd));
        chk("result_we", 64'(rwe), 64'd1);
      end
      if (rv && rr) obs_ids.push_back(rid);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    iv = 1'b0; cv = 1'b0; ckill = 1'b0; clr = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    idle();
  endtask

  task automatic issue(input logic [ID_W-1:0] id, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [6:0] opc);
    iv = 1'b1; iid = id; rs1 = a; rs2 = b;
    instr = {17'd0, f3, rd, opc};
  endtask

  task automatic commit(input logic [ID_W-1:0] id, input bit kill);
    cv = 1'b1; cid = id; ckill = kill;
  endtask

  int cand[$];
  logic [ID_W-1:0] nid;
  logic [2:0] f3r;
  logic [6:0] opr;
  bit will_push;
  int r;

  initial begin
    rr = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    #2;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_valid", 64'(rv), 64'd0);
    chk("reset_fields", {rdata[31:0], 16'd0, 8'(rid), 3'd0, rrd}, 64'd0);
    chk("reset_we", 64'(rwe), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD 5+7, commit next cycle
    issue(3'd2, 3'd0, 5'd10, 64'd5, 64'd7, OPC);
    step();
    commit(3'd2, 1'b0);
    step(); #2;
    chk("add_valid", 64'(rv), 64'd1);
    chk("add_data", rdata, 64'd12);
    chk("add_rd", 64'(rrd), 64'd10);
    chk("add_id", 64'(rid), 64'd2);
    chk("add_we", 64'(rwe), 64'd1);
    step();

    // non-custom opcode is rejected and never produces a result
    obs_ids.delete();
    issue(3'd5, 3'd0, 5'd3, 64'd1, 64'd1, 7'b0110011);
    #2 chk("reject_accept", 64'(accept), 64'd0);
    repeat (4) step();
    chk("reject_no_result", 64'(obs_ids.size()), 64'd0);

    // same-cycle issue+commit on empty queue: SLL and SLTU
    issue(3'd6, 3'd2, 5'd3, 64'd1, 64'h41, OPC); commit(3'd6, 1'b0);
    step(); #2;
    chk("sll_bypass_valid", 64'(rv), 64'd1);
    chk("sll_data", rdata, 64'd2);
    issue(3'd7, 3'd3, 5'd4, 64'd5, 64'd9, OPC); commit(3'd7, 1'b0);
    step(); #2;
    chk("sltu_data", rdata, 64'd1);
    step();

    // fill, then commit out of order
    obs_ids.delete();
    for (int i = 0; i < 4; i++) begin
      issue(3'(i), 3'd0, 5'(i), 64'(i), 64'd100, OPC);
      step();
    end
    #2 chk("full_ready", 64'(ready), 64'd0);
    commit(3'd3, 1'b0); step();
    commit(3'd1, 1'b0); step();
    commit(3'd0, 1'b0); step();
    commit(3'd2, 1'b0); step();
    repeat (4) step();
    chk("order_count", 64'(obs_ids.size()), 64'd4);
    for (int i = 0; i < 4 && i < obs_ids.size(); i++) chk("order_id", 64'(obs_ids[i]), 64'(i));

    // kill id 0, commit id 1
    obs_ids.delete();
    issue(3'd0, 3'd0, 5'd1, 64'd1, 64'd1, OPC); step();
    issue(3'd1, 3'd1, 5'd2, 64'd3, 64'd6, OPC); step();
    commit(3'd0, 1'b1); step();
    commit(3'd1, 1'b0); step(); #2;
    chk("kill_valid", 64'(rv), 64'd1);
    chk("kill_id", 64'(rid), 64'd1);
    chk("kill_data", rdata, 64'd5);
    repeat (3) step();
    chk("kill_count", 64'(obs_ids.size()), 64'd1);

    // result backpressure
    rr = 1'b0;
    issue(3'd4, 3'd1, 5'd7, 64'hF0, 64'h0F, OPC); step();
    issue(3'd5, 3'd0, 5'd8, 64'd20, 64'd22, OPC); step();
    commit(3'd4, 1'b0); step();
    commit(3'd5, 1'b0); step();
    repeat (5) begin
      step(); #2;
      chk("bp_valid", 64'(rv), 64'd1);
      chk("bp_id", 64'(rid), 64'd4);
      chk("bp_data", rdata, 64'hFF);
    end
    rr = 1'b1;
    step(); #2;
    chk("bp_second_valid", 64'(rv), 64'd1);
    chk("bp_second_id", 64'(rid), 64'd5);
    chk("bp_second_data", rdata, 64'd42);
    step(); step();

    // flush with queued entries and a pending result
    rr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(3'(i), 3'd0, 5'd1, 64'd1, 64'd1, OPC);
      step();
    end
    commit(3'd0, 1'b0); step(); #2;
    chk("clr_pre_valid", 64'(rv), 64'd1);
    clr = 1'b1;
    step(); #2;
    chk("clr_valid", 64'(rv), 64'd0);
    chk("clr_ready", 64'(ready), 64'd1);
    rr = 1'b1;
    obs_ids.delete();
    for (int i = 1; i < 4; i++) begin
      commit(3'(i), 1'b0);
      step();
    end
    repeat (2) step();
    chk("clr_no_results", 64'(obs_ids.size()), 64'd0);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rr  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 149) == 0);
      will_push = 1'b0;
      if ($urandom_range(0, 2) != 0) begin
        do nid = 3'($urandom_range(0, 7)); while (in_q(nid));
        f3r = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        opr = ($urandom_range(0, 15) == 0) ? 7'b0110011 : OPC;
        issue(nid, f3r, 5'($urandom_range(0, 31)), {$urandom, $urandom},
              ($urandom_range(0, 7) == 0) ? rs1 : {$urandom, $urandom}, opr);
        will_push = (mq.size() < DEPTH) && dec_ok(instr) && !clr;
      end
      cand.delete();
      foreach (mq[k]) if (!mq[k].com && !mq[k].kil) cand.push_back(k);
      r = $urandom_range(0, 9);
      if (r < 6 && cand.size() > 0) begin
        commit(mq[cand[$urandom_range(0, cand.size() - 1)]].id, ($urandom_range(0, 4) == 0));
      end else if (r < 8 && will_push) begin
        commit(iid, ($urandom_range(0, 4) == 0));
      end else if (r == 8) begin
        do nid = 3'($urandom_range(0, 7)); while (in_q(nid) || (iv && nid == iid));
        commit(nid, 1'b0);
      end
      step();
    end
    rr = 1'b1;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cvxif_copro_issue_queue.md
# cvxif_copro_issue_queue

Coprocessor-side front end for the CV-X-IF issue/commit/result channels between the cva6 core and a custom-0 coprocessor. It accepts offloaded instructions and holds them in an in-order queue until the core commits or kills them. Committed instructions run through a single-cycle ALU, and the result is returned through a registered result port with backpressure. It replaces the ad-hoc handshaking in the example coprocessor and sits directly downstream of the core's CV-X-IF request port.

## Interface
- DEPTH, 4: queue entries, power of two, ≥2
- ID_W, 3: instruction id width
- XLEN, 64: operand/result width
- OPCODE, 7'b0001011: accepted major opcode (custom-0)

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  reset; asynchronous, active-low
- clr_i  in  1  synchronous flush of all state
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  queue can take an issue
- issue_instr_i  in  32  instruction word
- issue_rs1_i  in  XLEN  source operand 1
- issue_rs2_i  in  XLEN  source operand 2
- issue_id_i  in  ID_W  instruction id
- issue_accept_o  out  1  instruction accepted; valid during issue handshake
- issue_writeback_o  out  1  accepted instruction will write rd
- commit_valid_i  in  1  commit/kill strobe
- commit_id_i  in  ID_W  id being committed or killed
- commit_kill_i  in  1  1 = kill, 0 = commit
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  ID_W  id of result
- result_data_o  out  XLEN  result value
- result_rd_o  out  5  destination register
- result_we_o  out  1  register write enable

## Operation
- issue_ready_o = (count < DEPTH), taken from registered count only. A pop in the same cycle does not raise ready.
- Decode is combinational on issue_instr_i.
  - Accepted iff opcode == OPCODE and funct3 ∈ {000 ADD, 001 XOR, 010 SLL (rs2[5:0]), 011 SLTU}.
  - issue_accept_o and issue_writeback_o are both 1 when accepted, otherwise 0. They are 0 whenever no handshake occurs.
- On handshake (valid & ready) with accept, push entry {id, rd, funct3, rs1, rs2, committed=0, killed=0} at the tail. Rejected instructions are not stored.
- Commit/kill matching:
  - commit_valid_i is compared against every occupied entry and against the entry being pushed in the same cycle.
  - A match sets committed, or killed if commit_kill_i = 1.
  - A commit matching no entry is ignored.
  - Ids are unique among in-flight entries; the core guarantees this.
- Head processing, at most one pop per cycle:
  - Head killed: pop with no result.
  - Head committed and output register free (result_valid_o = 0, or result_ready_i = 1): compute result, load output register, pop.
  - Otherwise: hold.
- Arithmetic is modulo 2^XLEN. SLTU result is zero-extended 0/1.
- result_* fields stay stable while result_valid_o = 1 and result_ready_i = 0.
- clr_i:
  - Next cycle: count = 0, result_valid_o = 0, all entries invalid.
  - Overrides issue push, commit and pop in the same cycle.
  - issue_accept_o still reflects decode.

## Timing
- Reset (rst_ni low, async):
  - issue_ready_o = 1, result_valid_o = 0.
  - result_id_o, result_data_o, result_rd_o, result_we_o = 0.
  - count = 0, head = tail = 0.
- Latency:
  - Head commit at cycle N (entry already queued, output free) → result_valid_o at N+1.
  - Issue and commit of the same id at cycle N → result_valid_o at N+1 only if the queue was empty; otherwise in order after older entries.
- Throughput: one result per cycle while result_ready_i = 1 and the head is committed.
- Pointers wrap modulo DEPTH. count is ID-independent and ranges 0..DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full (count = DEPTH): issue_ready_o = 0 and issue_accept_o is don't-care. Commits are still processed.

## Test plan
- Reset, then issue ADD rs1 = 5, rs2 = 7, id = 2, rd = 10; commit id 2 the next cycle → result_valid_o one cycle after commit with data = 12, rd = 10, id = 2, we = 1.
- Issue a non-custom opcode (0110011) → issue_accept_o = 0, queue count stays 0, no result ever.
- Issue ids 0, 1, 2, 3 (DEPTH = 4) → issue_ready_o = 0 in the cycle after the 4th push. Commit ids in order 3, 1, 0, 2 → results emerge in order 0, 1, 2, 3.
- Issue ids 0 and 1; kill id 0, commit id 1 → only id 1 result, one cycle after the later of the kill pop and the commit.
- Result backpressure: result_ready_i = 0 for 5 cycles with 2 committed entries → result_valid_o held and fields stable, count stays 1. Raising ready → second result the next cycle.
- Assert clr_i with 3 queued entries and result_valid_o = 1 → next cycle result_valid_o = 0, issue_ready_o = 1. Later commits of the old ids produce nothing.
